// File: rtl/nios_system_nios2_oci_dct_packer.sv
// nios_system_nios2_oci_dct_packer
//
// Producer side of the OCI direct-compressed-trace interface. Trace codes
// are packed into a shift accumulator, with the newest code in the low bits.
// Full or flushed frames are handed to the trace-memory writer through a
// single-entry valid/ready slot. When the test ends, the block drains any
// partial frame and then raises test_has_ended.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   code_valid, code    incoming trace code (no backpressure)
//   flush               single-cycle pulse: emit the partial frame
//   test_ending         level: stop accepting codes and drain
//   frame_ready         writer accepts the frame in the slot
//   frame_valid/_data/_count   frame slot contents
//   dct_buffer/dct_count       live accumulator
//   overflow, drop_count       sticky drop flag, saturating drop counter
//   test_has_ended             drain complete
module nios_system_nios2_oci_dct_packer #(
    parameter int unsigned CODE_W = 2,
    parameter int unsigned DEPTH  = 15,
    parameter int unsigned DROP_W = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          code_valid,
    input  logic [CODE_W-1:0]             code,
    input  logic                          flush,
    input  logic                          test_ending,
    input  logic                          frame_ready,
    output logic                          frame_valid,
    output logic [CODE_W*DEPTH-1:0]       frame_data,
    output logic [$clog2(DEPTH+1)-1:0]    frame_count,
    output logic [CODE_W*DEPTH-1:0]       dct_buffer,
    output logic [$clog2(DEPTH+1)-1:0]    dct_count,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          test_has_ended
);

    localparam int unsigned BUF_W = CODE_W * DEPTH;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_ENDED
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [BUF_W-1:0]   r_buf;
    logic [CNT_W-1:0]   r_count;
    logic               r_frame_valid;
    logic [BUF_W-1:0]   r_frame_data;
    logic [CNT_W-1:0]   r_frame_count;
    logic               r_flush_pend;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_count;

    logic [BUF_W-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_frame_valid_nxt;
    logic [BUF_W-1:0]   w_frame_data_nxt;
    logic [CNT_W-1:0]   w_frame_count_nxt;
    logic               w_flush_pend_nxt;

    logic               w_slot_free;
    logic               w_full;
    logic               w_accept;
    logic               w_drop;
    logic [BUF_W-1:0]   w_shifted;
    logic               w_nonempty;
    logic               w_cap_full;
    logic               w_cap_flush;
    logic               w_capture;
    logic               w_ended;

    // Slot / accept / capture decisions
    always_comb begin
        w_slot_free = !r_frame_valid || frame_ready;
        w_full      = (r_count == CNT_FULL);
        w_accept    = code_valid && (r_state == S_RUN) && (!w_full || w_slot_free);
        w_drop      = code_valid && !w_accept;
        w_shifted   = {r_buf[BUF_W-CODE_W-1:0], code};
        w_nonempty  = (r_count != '0) || w_accept;
        w_cap_full  = w_full || ((r_count == CNT_ALMOST) && w_accept);
        w_cap_flush = (r_flush_pend || flush || (r_state == S_DRAIN)) && w_nonempty;
        w_capture   = (w_cap_full || w_cap_flush) && w_slot_free;
    end

    // Accumulator and frame slot next values
    always_comb begin
        w_buf_nxt         = r_buf;
        w_count_nxt       = r_count;
        w_frame_data_nxt  = r_frame_data;
        w_frame_count_nxt = r_frame_count;
        w_frame_valid_nxt = r_frame_valid && !frame_ready;

        if (w_capture) begin
            w_frame_valid_nxt = 1'b1;
            if (w_full) begin
                // A full buffer has no room to shift, so capture it as-is
                // and let an accepted code start the next frame.
                w_frame_data_nxt  = r_buf;
                w_frame_count_nxt = r_count;
                if (w_accept) begin
                    w_buf_nxt   = BUF_W'(code);
                    w_count_nxt = CNT_W'(1);
                end else begin
                    w_buf_nxt   = '0;
                    w_count_nxt = '0;
                end
            end else begin
                if (w_accept) begin
                    w_frame_data_nxt  = w_shifted;
                    w_frame_count_nxt = r_count + CNT_W'(1);
                end else begin
                    w_frame_data_nxt  = r_buf;
                    w_frame_count_nxt = r_count;
                end
                w_buf_nxt   = '0;
                w_count_nxt = '0;
            end
        end else if (w_accept) begin
            w_buf_nxt   = w_shifted;
            w_count_nxt = r_count + CNT_W'(1);
        end

        // A flush that finds an occupied slot is remembered until the next
        // capture. A flush with nothing to emit is ignored.
        if (w_capture) begin
            w_flush_pend_nxt = 1'b0;
        end else if (flush && w_nonempty) begin
            w_flush_pend_nxt = 1'b1;
        end else begin
            w_flush_pend_nxt = r_flush_pend;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf         <= '0;
            r_count       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_count <= '0;
            r_flush_pend  <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_buf         <= w_buf_nxt;
            r_count       <= w_count_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_frame_data  <= w_frame_data_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_flush_pend  <= w_flush_pend_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + DROP_W'(1);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ended     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (test_ending) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_count == '0) && !r_frame_valid) begin
                    w_state_nxt = S_ENDED;
                end
            end
            S_ENDED: begin
                w_ended = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign frame_valid    = r_frame_valid;
    assign frame_data     = r_frame_data;
    assign frame_count    = r_frame_count;
    assign dct_buffer     = r_buf;
    assign dct_count      = r_count;
    assign overflow       = r_overflow;
    assign drop_count     = r_drop_count;
    assign test_has_ended = w_ended;

endmodule

// File: tb/tb_nios_system_nios2_oci_dct_packer.sv
// tb_nios_system_nios2_oci_dct_packer
//
// Directed bench for the DCT packer. Every expected value is a constant
// worked out by hand from the packing rules.
module tb_nios_system_nios2_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        code_valid;
    logic [1:0]  code;
    logic        flush;
    logic        test_ending;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        test_has_ended;

    int n_checks;
    int n_errors;

    nios_system_nios2_oci_dct_packer #(
        .CODE_W (2),
        .DEPTH  (15),
        .DROP_W (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .code_valid     (code_valid),
        .code           (code),
        .flush          (flush),
        .test_ending    (test_ending),
        .frame_ready    (frame_ready),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        code_valid  = 1'b0;
        flush       = 1'b0;
        test_ending = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        code_valid  = 1'b0;
        code        = 2'd0;
        flush       = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b1;
        tick();
        tick();
        check("rst_fv",    32'(frame_valid), 32'd0);
        check("rst_cnt",   32'(dct_count), 32'd0);
        check("rst_ended", 32'(test_has_ended), 32'd0);
        check("rst_drop",  32'(drop_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Full frame of 0,1,2,3,... with the writer always ready
        for (int i = 0; i < 15; i++) begin
            code_valid = 1'b1;
            code = 2'(i % 4);
            tick();
            if (i == 0) check("t1_cnt1", 32'(dct_count), 32'd1);
            if (i == 2) check("t1_buf3", 32'(dct_buffer), 32'h6);
            if (i == 13) check("t1_cnt14_fv", 32'(frame_valid), 32'd0);
        end
        code_valid = 1'b0;
        check("t1_fv",   32'(frame_valid), 32'd1);
        check("t1_fc",   32'(frame_count), 32'd15);
        check("t1_fd",   32'(frame_data), 32'h06C6C6C6);
        check("t1_cnt0", 32'(dct_count), 32'd0);
        tick();
        check("t1_fv_fall", 32'(frame_valid), 32'd0);
        check("t1_ovf",     32'(overflow), 32'd0);

        // Partial frame 3,2,1 emitted by flush
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1;
            code = 2'(3 - i);
            tick();
        end
        code_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t2_fv",  32'(frame_valid), 32'd1);
        check("t2_fc",  32'(frame_count), 32'd3);
        check("t2_fd",  32'(frame_data), 32'h39);
        check("t2_cnt", 32'(dct_count), 32'd0);
        tick();
        check("t2_fv_fall", 32'(frame_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t2_empty_flush", 32'(frame_valid), 32'd0);

        // Writer stalled: one frame held, accumulator fills, rest dropped
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 46; i++) begin
            code_valid = 1'b1;
            code = 2'(i % 4);
            tick();
            if (i == 29) begin
                check("t3_acc_cnt", 32'(dct_count), 32'd15);
                check("t3_acc_buf", 32'(dct_buffer), 32'h31B1B1B1);
                check("t3_held_fv", 32'(frame_valid), 32'd1);
                check("t3_held_fc", 32'(frame_count), 32'd15);
            end
        end
        code_valid = 1'b0;
        check("t3_ovf",     32'(overflow), 32'd1);
        check("t3_drop",    32'(drop_count), 32'd16);
        check("t3_cnt",     32'(dct_count), 32'd15);
        check("t3_held_fd", 32'(frame_data), 32'h06C6C6C6);
        frame_ready = 1'b1;
        tick();
        check("t3_f2_fv",  32'(frame_valid), 32'd1);
        check("t3_f2_fd",  32'(frame_data), 32'h31B1B1B1);
        check("t3_f2_fc",  32'(frame_count), 32'd15);
        check("t3_f2_cnt", 32'(dct_count), 32'd0);
        tick();
        check("t3_f2_fall", 32'(frame_valid), 32'd0);

        // Full accumulator, slot frees in the same cycle a code arrives
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            code_valid = 1'b1;
            code = 2'(i % 4);
            tick();
        end
        frame_ready = 1'b1;
        code_valid = 1'b1;
        code = 2'd2;
        tick();
        code_valid = 1'b0;
        frame_ready = 1'b0;
        check("t4_fv",   32'(frame_valid), 32'd1);
        check("t4_fd",   32'(frame_data), 32'h31B1B1B1);
        check("t4_fc",   32'(frame_count), 32'd15);
        check("t4_cnt",  32'(dct_count), 32'd1);
        check("t4_buf",  32'(dct_buffer), 32'h2);
        check("t4_drop", 32'(drop_count), 32'd0);
        check("t4_ovf",  32'(overflow), 32'd0);

        // End-of-test drain
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            code_valid = 1'b1;
            code = 2'((i + 1) % 4);
            tick();
        end
        code_valid = 1'b0;
        test_ending = 1'b1;
        tick();
        check("t5_not_ended0", 32'(test_has_ended), 32'd0);
        for (int i = 0; i < 4; i++) begin
            code_valid = (i % 2 == 0);
            code = 2'd3;
            tick();
        end
        code_valid = 1'b0;
        check("t5_fv",    32'(frame_valid), 32'd1);
        check("t5_fc",    32'(frame_count), 32'd5);
        check("t5_fd",    32'(frame_data), 32'h1B1);
        check("t5_cnt",   32'(dct_count), 32'd0);
        check("t5_drop",  32'(drop_count), 32'd2);
        check("t5_ovf",   32'(overflow), 32'd1);
        check("t5_not_ended1", 32'(test_has_ended), 32'd0);
        frame_ready = 1'b1;
        tick();
        check("t5_fv_fall",    32'(frame_valid), 32'd0);
        check("t5_not_ended2", 32'(test_has_ended), 32'd0);
        tick();
        check("t5_ended", 32'(test_has_ended), 32'd1);
        test_ending = 1'b0;
        frame_ready = 1'b0;
        tick();
        tick();
        check("t5_ended_hold", 32'(test_has_ended), 32'd1);
        code_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        code_valid = 1'b0;
        check("t5_drop_sat",   32'(drop_count), 32'd255);
        check("t5_ended_hold2", 32'(test_has_ended), 32'd1);

        // Asynchronous reset with a held frame and 7 codes accumulated
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            code_valid = 1'b1;
            code = 2'(i % 4);
            tick();
        end
        code_valid = 1'b0;
        check("t6_pre_fv",  32'(frame_valid), 32'd1);
        check("t6_pre_cnt", 32'(dct_count), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_fv",   32'(frame_valid), 32'd0);
        check("t6_fd",   32'(frame_data), 32'd0);
        check("t6_fc",   32'(frame_count), 32'd0);
        check("t6_buf",  32'(dct_buffer), 32'd0);
        check("t6_cnt",  32'(dct_count), 32'd0);
        check("t6_ovf",  32'(overflow), 32'd0);
        check("t6_drop", 32'(drop_count), 32'd0);
        check("t6_end",  32'(test_has_ended), 32'd0);
        tick();
        reset_n = 1'b1;
        frame_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t6_post_fv",  32'(frame_valid), 32'd0);
        check("t6_post_cnt", 32'(dct_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
